// File: rtl/ram_mport_pkg.sv
// Shared types and helpers for the multi-port scratchpad RAM: clear FSM states,
// access-length saturation and wrapped element indexing.
package ram_mport_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_t;

   // Lengths above the lane count collapse to a full-bus access.
   function automatic int unsigned sat_len(input int unsigned len, input int unsigned n_el);
      return (len > n_el) ? n_el : len;
   endfunction

   // Depth is a power of two, so wrapping is a mask rather than a divide.
   function automatic int unsigned wrap_idx(input int unsigned base, input int unsigned offs,
                                            input int unsigned depth);
      return (base + offs) & (depth - 1);
   endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return delay line: carries one read's data and valid through `latency` stages.
// Data registers only load on a valid beat, so the output holds between reads.
module ram_rd_pipe #(
   parameter int width   = 256,
   parameter int latency = 1
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             in_valid,
   input  logic [width-1:0] in_data,
   output logic             out_valid,
   output logic [width-1:0] out_data
);

   logic [latency-1:0]            stage_valid;
   logic [latency-1:0][width-1:0] stage_data;

   // NOTE: sequential state uses non-blocking assignments so every stage samples
   // the value its predecessor held before this edge, regardless of statement order.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         stage_valid <= '0;
         stage_data  <= '0;
      end else begin
         stage_valid[0] <= in_valid;
         if (in_valid)
            stage_data[0] <= in_data;
         for (int s = 1; s < latency; s++) begin
            stage_valid[s] <= stage_valid[s-1];
            if (stage_valid[s-1])
               stage_data[s] <= stage_data[s-1];
         end
      end
   end

   assign out_valid = stage_valid[latency-1];
   assign out_data  = stage_data[latency-1];

endmodule

// File: rtl/ram_mport.sv
// Shared activation/weight buffer: nWr masked multi-element write ports, nRd pipelined
// read ports, highest-port-wins write merging and a hardware clear sequencer.
module ram_mport
   import ram_mport_pkg::*;
#(
   parameter  int dataSize  = 8,
   parameter  int busWidth  = 256,
   parameter  int depth     = 1024,
   parameter  int addrWidth = 32,
   parameter  int nWr       = 2,
   parameter  int nRd       = 2,
   parameter  int rdLatency = 1,
   localparam int nEl       = busWidth / dataSize,
   localparam int lenWidth  = $clog2(nEl + 1)
) (
   input  logic                               clk,
   input  logic                               nrst,
   input  logic                               clear_i,
   output logic                               busy_o,
   input  logic [nWr-1:0]                     wr_en_i,
   input  logic [nWr-1:0][addrWidth-1:0]      wr_addr_i,
   input  logic [nWr-1:0][lenWidth-1:0]       wr_len_i,
   input  logic [nWr-1:0][nEl-1:0]            wr_mask_i,
   input  logic [nWr-1:0][busWidth-1:0]       wr_data_i,
   input  logic [nRd-1:0]                     rd_en_i,
   input  logic [nRd-1:0][addrWidth-1:0]      rd_addr_i,
   input  logic [nRd-1:0][lenWidth-1:0]       rd_len_i,
   output logic [nRd-1:0][busWidth-1:0]       rd_data_o,
   output logic [nRd-1:0]                     rd_valid_o,
   output logic                               wr_collide_o
);

   localparam int idxWidth = (depth > 1) ? $clog2(depth) : 1;
   localparam int ptrWidth = $clog2(depth + nEl + 1);

   logic [dataSize-1:0]  mem [depth];

   clr_state_t           state, state_next;
   logic [ptrWidth-1:0]  clr_ptr;
   logic                 clr_last;
   logic                 busy;

   logic [idxWidth-1:0]  wr_idx [nWr][nEl];
   logic [nWr-1:0][nEl-1:0] wr_lane;
   logic                 collide;
   logic [nRd-1:0][busWidth-1:0] rd_word;

   // Address bits above the array index are ignored by design.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{wr_addr_i, rd_addr_i};

   // ---------------------------------------------------------------- clear FSM
   assign clr_last = (32'(clr_ptr) + nEl) >= depth;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state   <= ST_IDLE;
         clr_ptr <= '0;
      end else begin
         state <= state_next;
         if (clear_i)
            clr_ptr <= '0;
         else if (state == ST_CLEAR)
            clr_ptr <= clr_ptr + ptrWidth'(nEl);
      end
   end

   // NOTE: every always_comb output gets a default before any branch so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (clear_i) state_next = ST_CLEAR;
         ST_CLEAR: if (!clear_i && clr_last) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == ST_CLEAR);
   end

   assign busy_o = busy;

   // ---------------------------------------------------------------- write lanes
   always_comb begin
      for (int p = 0; p < nWr; p++) begin
         for (int i = 0; i < nEl; i++) begin
            wr_idx[p][i]  = idxWidth'(wrap_idx(32'(wr_addr_i[p][idxWidth-1:0]), i, depth));
            wr_lane[p][i] = wr_en_i[p] && !busy && wr_mask_i[p][i]
                            && (i < sat_len(32'(wr_len_i[p]), nEl));
         end
      end
   end

   always_comb begin
      collide = 1'b0;
      for (int p = 0; p < nWr; p++)
         for (int q = p + 1; q < nWr; q++)
            for (int i = 0; i < nEl; i++)
               for (int k = 0; k < nEl; k++)
                  if (wr_lane[p][i] && wr_lane[q][k] && (wr_idx[p][i] == wr_idx[q][k]))
                     collide = 1'b1;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         wr_collide_o <= 1'b0;
      else if (clear_i)
         wr_collide_o <= 1'b0;
      else if (collide)
         wr_collide_o <= 1'b1;
   end

   // NOTE: the array has no reset; contents survive nrst and are zeroed only by
   // the clear sequencer, which keeps the storage mappable onto SRAM macros.
   // Later ports overwrite earlier ones in loop order, giving highest-port priority.
   always_ff @(posedge clk) begin
      if (busy) begin
         for (int i = 0; i < nEl; i++)
            mem[idxWidth'(wrap_idx(32'(clr_ptr), i, depth))] <= '0;
      end else begin
         for (int p = 0; p < nWr; p++)
            for (int i = 0; i < nEl; i++)
               if (wr_lane[p][i])
                  mem[wr_idx[p][i]] <= wr_data_i[p][(nEl-1-i)*dataSize +: dataSize];
      end
   end

   // ---------------------------------------------------------------- read ports
   // Reads sample the array before this edge's writes land, giving read-first.
   always_comb begin
      for (int p = 0; p < nRd; p++) begin
         rd_word[p] = '0;
         if (!busy) begin
            for (int i = 0; i < nEl; i++)
               if (i < sat_len(32'(rd_len_i[p]), nEl))
                  rd_word[p][(nEl-1-i)*dataSize +: dataSize] =
                     mem[idxWidth'(wrap_idx(32'(rd_addr_i[p][idxWidth-1:0]), i, depth))];
         end
      end
   end

   for (genvar p = 0; p < nRd; p++) begin : g_rd
      ram_rd_pipe #(
         .width   (busWidth),
         .latency (rdLatency)
      ) u_pipe (
         .clk       (clk),
         .nrst      (nrst),
         .in_valid  (rd_en_i[p]),
         .in_data   (rd_word[p]),
         .out_valid (rd_valid_o[p]),
         .out_data  (rd_data_o[p])
      );
   end

endmodule

// File: doc/ram_mport.md
# ram_mport

Parametrised multi-port scratchpad RAM that generalises the team's fixed two-write/two-read memory. It has configurable write-port and read-port counts, a common bus width, and per-access element counts and element masks. Read latency is configurable and read data carries a valid flag. A hardware clear sequencer zeroes the array. The block sits between the CSR/host loader (narrow accesses) and the accelerator datapath (wide accesses) as the shared activation/weight buffer.

## Interface
- dataSize, 8: bits per element (addressable unit)
- busWidth, 256: bits per port data bus; nEl = busWidth/dataSize, integer, ≥1
- depth, 1024: elements in array; power of two
- addrWidth, 32: address bits; only low log2(depth) bits used
- nWr, 2: write ports
- nRd, 2: read ports
- rdLatency, 1: cycles from accepted read to rd_valid, 1..4
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- clear_i  in  1  pulse: start zeroing the whole array
- busy_o  out  1  clear in progress
- wr_en_i  in  nWr  per-port write strobe
- wr_addr_i  in  nWr×addrWidth  start element address
- wr_len_i  in  nWr×$clog2(nEl+1)  elements to write, 0..nEl
- wr_mask_i  in  nWr×nEl  per-element enable, bit i ↔ element i
- wr_data_i  in  nWr×busWidth  write data
- rd_en_i  in  nRd  per-port read strobe
- rd_addr_i  in  nRd×addrWidth  start element address
- rd_len_i  in  nRd×$clog2(nEl+1)  elements to return
- rd_data_o  out  nRd×busWidth  read data
- rd_valid_o  out  nRd  rd_data_o valid this cycle
- wr_collide_o  out  1  sticky: two ports wrote one element in one cycle; cleared by clear_i

## Operation
- Element placement: element at address a+i maps to bus bits [(nEl-1-i)*dataSize +: dataSize], for both read and write. The first element sits in the MSB slot.
- Write: on wr_en_i[p], element i (i < wr_len_i[p], wr_mask_i[p][i]=1) is stored at (wr_addr_i[p]+i) mod depth. Other elements are untouched.
- Read: on rd_en_i[p], element i (i < rd_len_i[p]) is returned from (rd_addr_i[p]+i) mod depth. Slots i ≥ rd_len_i are driven 0.
- len = 0 is a no-op for writes. For reads it still produces rd_valid, with all-zero data.
- len > nEl is saturated to nEl.
- Address wrap: indices wrap modulo depth. No error is raised.
- Write collision: if two or more ports target the same element in one cycle, the highest port index wins. wr_collide_o is set.
- Read-during-write on the same element in the same cycle: read returns the old (pre-write) value (read-first).
- Clear FSM, states IDLE and CLEAR:
  - IDLE→CLEAR on clear_i. busy_o=1 and an internal pointer starts at 0.
  - In CLEAR, nEl elements are zeroed per cycle and the pointer advances by nEl.
  - CLEAR→IDLE when the pointer reaches depth; busy_o falls the same edge.
  - clear_i while in CLEAR restarts the pointer at 0.
- While busy_o=1:
  - Writes are dropped.
  - Reads are accepted and return all-zero data with normal latency and valid.
- wr_collide_o is cleared on clear_i.

## Timing
- Reset (nrst low, async):
  - rd_data_o = 0, rd_valid_o = 0, busy_o = 0, wr_collide_o = 0.
  - FSM returns to IDLE and the read pipeline is flushed.
  - Memory contents are not reset.
- Write: visible to a read issued the following cycle.
- Read latency: rd_valid_o[p] and data appear exactly rdLatency edges after the rd_en_i edge. Fully pipelined, one read per port per cycle.
- rd_data_o holds its last value when rd_valid_o is low.
- Clear duration: depth/nEl cycles, rounded up. busy_o is high from the edge after clear_i for exactly that many cycles.
- Reset mid-clear: the FSM aborts to IDLE. Partially cleared contents remain.

## Structure
- Package ram_mport_pkg: clear FSM state enum, and functions for len saturation and wrapped index.
- Sub-module ram_rd_pipe: per-read-port delay line of depth rdLatency carrying data and valid. Instantiate nRd times.
- Top level holds the array, write-merge/priority logic, collision detect and clear FSM.

## Test plan
- Defaults: port0 writes addr 0x10, len 4, mask 1111, data 0x11223344 in top 32 bits. port1 reads addr 0x10, len 4 → after 1 cycle rd_valid=1, top 32 bits 0x11223344, rest 0.
- Wrap: write addr depth-2, len 4, data AA BB CC DD → reads at addr depth-2 and addr 0 return AA BB and CC DD respectively.
- Collision: port0 and port1 both write addr 5, len 1, data 0x01 and 0x02 in the same cycle → read returns 0x02, wr_collide_o=1.
- Read-first: write 0x7E to addr 9 while reading addr 9 (old 0x00) in the same cycle → read returns 0x00. Next read returns 0x7E.
- rdLatency=3 with back-to-back reads on 4 cycles → four valids, 3 cycles after each request, in order, no bubbles.
- Clear: fill memory, pulse clear_i → busy_o high for depth/nEl cycles, writes during busy ignored. Afterwards every read returns 0 and wr_collide_o=0.
